// File: rtl/ram_param_if.sv
// Bus bundle for ram_param: access request from the datapath and registered read/status back.
interface ram_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
);
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic              re;
  logic              clr;
  logic [DATA_W-1:0] q;
  logic              q_valid;
  logic              busy;
  logic              err;

  modport master (
    output data, addr, we, re, clr,
    input  q, q_valid, busy, err
  );

  modport slave (
    input  data, addr, we, re, clr,
    output q, q_valid, busy, err
  );
endinterface

// File: rtl/ram_param.sv
// Parametrised single-port RAM with a registered read port and a clear sequencer
// that fills every word with CLR_VAL after reset or on request.
module ram_param #(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       ADDR_W   = 5,
  parameter int unsigned       DEPTH    = 32,
  parameter int unsigned       RDW_MODE = 0,
  parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
  input  logic        clk,
  input  logic        rst,
  ram_param_if.slave  bus
);
  localparam int unsigned      CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  clr_cnt, clr_cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  idx;
  logic              idle;
  logic              in_range;
  logic              wr_ok;

  assign idle     = (state == IDLE);
  assign idx      = bus.addr[CNT_W-1:0];
  // Zero-extended compare keeps DEPTH == 2**ADDR_W from overflowing the address width.
  assign in_range = ({1'b0, bus.addr} < (ADDR_W + 1)'(DEPTH));
  assign wr_ok    = idle && bus.we && in_range;
  assign bus.busy = (state == CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      CLEAR: begin
        clr_cnt_nxt = clr_cnt + CNT_W'(1);
        if (clr_cnt == LAST) begin
          state_nxt   = IDLE;
          clr_cnt_nxt = '0;
        end
      end
      IDLE: begin
        if (bus.clr) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  // Array has no reset; while rst is held the sequencer just rewrites word 0.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= CLR_VAL;
    end else if (wr_ok) begin
      mem[idx] <= bus.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.q       <= '0;
      bus.q_valid <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      bus.q_valid <= 1'b0;
      bus.err     <= 1'b0;
      if (idle) begin
        if ((bus.we || bus.re) && !in_range) begin
          bus.err <= 1'b1;
        end
        if (bus.re) begin
          bus.q_valid <= 1'b1;
          if (!in_range) begin
            bus.q <= CLR_VAL;
          end else if ((RDW_MODE != 0) && bus.we) begin
            bus.q <= bus.data;
          end else begin
            bus.q <= mem[idx];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ram_param.sv
// Scoreboard bench for ram_param: a full-depth read-first instance (a) and a
// 20-word write-first instance with CLR_VAL=0xA5 (b) share one stimulus stream.
module tb_ram_param;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ram_param_if #(.DATA_W(8), .ADDR_W(5)) ia ();
  ram_param_if #(.DATA_W(8), .ADDR_W(5)) ib ();

  ram_param #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .RDW_MODE(0), .CLR_VAL(8'h00)) u_a (
    .clk(clk), .rst(rst), .bus(ia)
  );
  ram_param #(.DATA_W(8), .ADDR_W(5), .DEPTH(20), .RDW_MODE(1), .CLR_VAL(8'hA5)) u_b (
    .clk(clk), .rst(rst), .bus(ib)
  );

  typedef struct packed {
    logic       v;
    logic       e;
    logic [7:0] q;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic score(input string name, input logic v, input logic e, input logic [7:0] q,
                       input exp_t x);
    checks++;
    if (v !== x.v || e !== x.e || (x.v && q !== x.q)) begin
      errors++;
      $display("FAIL %s: got valid=%0b err=%0b q=%0h expected valid=%0b err=%0b q=%0h",
               name, v, e, q, x.v, x.e, x.q);
    end
  endtask

  always @(negedge clk) begin
    if (ia.q_valid || ia.err) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_a: got valid=%0b err=%0b q=%0h expected no output",
                 ia.q_valid, ia.err, ia.q);
      end else begin
        score("mon_a", ia.q_valid, ia.err, ia.q, qa.pop_front());
      end
    end
    if (ib.q_valid || ib.err) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_b: got valid=%0b err=%0b q=%0h expected no output",
                 ib.q_valid, ib.err, ib.q);
      end else begin
        score("mon_b", ib.q_valid, ib.err, ib.q, qb.pop_front());
      end
    end
  end

  task automatic set_a(input logic w, input logic r, input logic c, input logic [4:0] a,
                       input logic [7:0] d);
    ia.we = w; ia.re = r; ia.clr = c; ia.addr = a; ia.data = d;
  endtask

  task automatic set_b(input logic w, input logic r, input logic c, input logic [4:0] a,
                       input logic [7:0] d);
    ib.we = w; ib.re = r; ib.clr = c; ib.addr = a; ib.data = d;
  endtask

  task automatic set_in(input logic w, input logic r, input logic c, input logic [4:0] a,
                        input logic [7:0] d);
    set_a(w, r, c, a, d);
    set_b(w, r, c, a, d);
  endtask

  // One accepted access; ea/eb are the hand-computed read results for a and b.
  task automatic access(input logic w, input logic r, input logic [4:0] a, input logic [7:0] d,
                        input logic [7:0] ea, input logic [7:0] eb);
    set_in(w, r, 1'b0, a, d);
    if (r) qa.push_back('{v: 1'b1, e: 1'b0, q: ea});
    if (r) qb.push_back('{v: 1'b1, e: (a >= 5'd20), q: eb});
    else if (w && a >= 5'd20) qb.push_back('{v: 1'b0, e: 1'b1, q: 8'h00});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic count_busy(input string tag);
    int da = 0;
    int db = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (da == 0 && !ia.busy) da = k;
      if (db == 0 && !ib.busy) db = k;
    end
    chk({tag, "_busy_edges_a"}, da, 32);
    chk({tag, "_busy_edges_b"}, db, 20);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_q_a"}, ia.q, 0);
    chk({tag, "_qv_a"}, ia.q_valid, 0);
    chk({tag, "_err_a"}, ia.err, 0);
    chk({tag, "_busy_a"}, ia.busy, 1);
    chk({tag, "_q_b"}, ib.q, 0);
    chk({tag, "_qv_b"}, ib.q_valid, 0);
    chk({tag, "_err_b"}, ib.err, 0);
    chk({tag, "_busy_b"}, ib.busy, 1);
  endtask

  task automatic read_all_cleared();
    for (int i = 0; i < 32; i++) access(1'b0, 1'b1, 5'(i), 8'd0, 8'h00, 8'hA5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1);
  end

  initial begin
    int da;
    int db;
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    count_busy("init");
    read_all_cleared();

    for (int i = 0; i < 20; i++) access(1'b1, 1'b0, 5'(i), 8'(i + 1), 8'd0, 8'd0);
    for (int i = 0; i < 20; i++) access(1'b0, 1'b1, 5'(i), 8'd0, 8'(i + 1), 8'(i + 1));

    // Read during write: a returns old data, b returns the written data.
    access(1'b1, 1'b0, 5'd5, 8'h11, 8'h00, 8'h00);
    access(1'b1, 1'b1, 5'd5, 8'h22, 8'h11, 8'h22);
    access(1'b0, 1'b1, 5'd5, 8'h00, 8'h22, 8'h22);

    // Out of range on b only.
    access(1'b1, 1'b0, 5'd25, 8'h77, 8'h00, 8'h00);
    access(1'b0, 1'b1, 5'd25, 8'h00, 8'h77, 8'hA5);
    access(1'b0, 1'b1, 5'd19, 8'h00, 8'd20, 8'd20);
    for (int i = 0; i < 5; i++) access(1'b0, 1'b1, 5'(i), 8'd0, 8'(i + 1), 8'(i + 1));
    access(1'b0, 1'b1, 5'd5, 8'h00, 8'h22, 8'h22);

    // Software clear with traffic hammering both instances while busy.
    for (int i = 0; i < 32; i++) access(1'b1, 1'b0, 5'(i), 8'hFF, 8'd0, 8'd0);
    set_in(1'b0, 1'b0, 1'b1, 5'd0, 8'd0);
    @(posedge clk);
    #1;
    chk("clr_busy_a", ia.busy, 1);
    chk("clr_busy_b", ib.busy, 1);
    da = 0;
    db = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k <= 32) set_a(1'b1, 1'b1, k[0], 5'(k), 8'h33);
      else set_a(1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
      if (k <= 20) set_b(1'b1, 1'b1, k[0], 5'(k), 8'h33);
      else set_b(1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
      @(posedge clk);
      #1;
      if (da == 0 && !ia.busy) da = k;
      if (db == 0 && !ib.busy) db = k;
    end
    chk("clr_busy_edges_a", da, 32);
    chk("clr_busy_edges_b", db, 20);
    read_all_cleared();

    // Reset ten steps into a clear; q must drop asynchronously from 0x5A.
    for (int i = 0; i < 32; i++) access(1'b1, 1'b0, 5'(i), 8'hFF, 8'd0, 8'd0);
    access(1'b1, 1'b0, 5'd3, 8'h5A, 8'd0, 8'd0);
    access(1'b0, 1'b1, 5'd3, 8'd0, 8'h5A, 8'h5A);
    idle(1);
    set_in(1'b0, 1'b0, 1'b1, 5'd0, 8'd0);
    @(posedge clk);
    #1;
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
    repeat (10) @(posedge clk);
    chk("midclr_q_before_a", ia.q, 8'h5A);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midclr");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    count_busy("midclr");
    read_all_cleared();

    idle(3);
    chk("queue_a_empty", qa.size(), 0);
    chk("queue_b_empty", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_param.md
# ram_param

Parametrised single-port synchronous RAM with registered read output, read-valid flag, selectable read-during-write behaviour, and a built-in clear sequencer. The sequencer zeroes the array after reset and on request. It replaces the fixed 8-bit x 32-word RAM as the general on-chip data/scratch memory of the processor, feeding the datapath through a one-cycle registered read.

## Interface
Parameters:
- DATA_W, 8, word width in bits (>=1)
- ADDR_W, 5, address width in bits (>=1)
- DEPTH, 32, number of implemented words, 1..2^ADDR_W
- RDW_MODE, 0, same-address read during write: 0 = old data (read-first), 1 = new data (write-first)
- CLR_VAL, 0, DATA_W-bit value written by the clear sequencer and returned for out-of-range reads

Ports:
- clk, in, 1, clock; all state changes on rising edge
- rst, in, 1, reset; one clock; reset is asynchronous and active-high
- data, in, DATA_W, write data
- addr, in, ADDR_W, word address for read and write
- we, in, 1, write enable
- re, in, 1, read enable
- clr, in, 1, clear request, sampled only when idle
- q, out, DATA_W, registered read data
- q_valid, out, 1, one-cycle pulse: q updated by an accepted read
- busy, out, 1, clear sequence in progress; we/re/clr ignored
- err, out, 1, one-cycle pulse: accepted access addressed a word >= DEPTH

## Operation
- State machine, two states: CLEAR and IDLE. A clear counter clr_cnt holds ceil(log2(DEPTH)) bits, minimum 1.
- While rst is high:
  - State is forced to CLEAR, with clr_cnt=0.
  - Outputs: q=0, q_valid=0, err=0, busy=1.
  - The array is not reset directly.
- CLEAR state:
  - Each edge writes CLR_VAL to mem[clr_cnt], then increments clr_cnt.
  - On the edge that writes word DEPTH-1, go to IDLE and set busy=0.
  - we, re and clr are ignored; q holds its value; q_valid=0; err=0.
- IDLE state, on each edge:
  - If we=1 and addr<DEPTH: mem[addr] <= data.
  - If re=1 and addr<DEPTH:
    - q <= mem[addr] and q_valid <= 1.
    - When we=1 in the same cycle, RDW_MODE selects old data (0) or data (1).
  - If (we or re)=1 and addr>=DEPTH:
    - err <= 1 and the write is dropped.
    - If re=1, q <= CLR_VAL and q_valid <= 1.
  - If clr=1: go to CLEAR with clr_cnt=0 and busy <= 1.
    - Any we/re in the same cycle is still performed first.
    - The written word is then overwritten when its turn comes.
  - If re=0, q holds its value and q_valid <= 0.
  - err <= 0 unless set by the out-of-range rule above.
- clr while busy has no effect; it does not restart the sequence.
- rst asserted mid-clear aborts immediately. After release, the clear restarts from word 0.
- Address comparison is unsigned, full ADDR_W bits. When DEPTH=2^ADDR_W, err never fires.

## Timing
- Number the rising edges after rst falls E1, E2, and so on.
- Ek writes word k-1, for k = 1..DEPTH. busy falls after E_DEPTH.
- The first access is accepted at E_(DEPTH+1).
- Read latency is 1 cycle: re/addr are sampled at edge N; q and q_valid are valid after edge N.
- Back-to-back reads on consecutive edges each produce their own q_valid pulse. Throughput is one read per cycle.
- A write at edge N is visible to a read sampled at edge N+1, in either mode.
- Software-requested clear: clr sampled at edge N sets busy=1 after N. Edges N+1..N+DEPTH write the array, and busy=0 after N+DEPTH.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Reset/clear, DEPTH=32, stale array contents: busy stays high for exactly 32 edges after rst release. A subsequent read of every address returns 0, each with q_valid pulsed one cycle after its re.
- Write/readback with DATA_W=8, ADDR_W=5: write data 1..20 to addresses 0..19, then read 0..19. Expect q = addr+1 one cycle after each re, with q_valid high for 20 consecutive cycles.
- Read-during-write: mem[5]=0x11, then we=re=1, addr=5, data=0x22.
  - RDW_MODE=0: q=0x11.
  - RDW_MODE=1: q=0x22.
  - A following read returns 0x22 in both modes.
- Out of range, DEPTH=20, CLR_VAL=0xA5:
  - Write addr 25: err pulses; no stored word changes.
  - Read addr 25: q=0xA5, q_valid=1, err=1.
  - Read addr 19: err=0.
- Clear request: fill the array with 0xFF and pulse clr. For DEPTH cycles, we/re are ignored (q_valid stays 0) and clr pulses have no effect. Afterwards all words read CLR_VAL.
- Reset mid-clear: assert rst at clear step 10 and check q=0, q_valid=0, err=0, busy=1 immediately, without waiting for a clock edge. After release, busy stays high for a full DEPTH edges and all words read CLR_VAL.
